// File: rtl/poly_memory_ctrl.sv
// poly_memory_ctrl: load/store engine between a single-port BRAM and the AMNS
// operand register bank (A, B, M, M'0, RES) of the Montgomery multiplier.
// Loads stream one address per cycle. A read-valid pipeline of depth RD_LAT
// tells the capture side when each word arrives. Stores stream RES out one
// word per cycle.
module poly_memory_ctrl #(
  parameter int WORD_WIDTH = 17,
  parameter int N          = 5,
  parameter int S          = 4,
  parameter int BRAM_WIDTH = 32,
  parameter int RD_LAT     = 1,
  parameter int ADDR_LEN   = $clog2(4*N*S+N)+1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load_start_i,
  input  logic                        load_mode_i,
  input  logic                        store_start_i,
  input  logic [ADDR_LEN-1:0]         base_addr_i,
  input  logic [BRAM_WIDTH-1:0]       bram_dout_i,
  input  logic                        res_we_i,
  input  logic [N*S*WORD_WIDTH-1:0]   res_din_i,
  output logic                        bram_we_o,
  output logic [ADDR_LEN-1:0]         bram_addr_o,
  output logic [BRAM_WIDTH-1:0]       bram_din_o,
  output logic [N*S*WORD_WIDTH-1:0]   A_reg_o,
  output logic [N*S*WORD_WIDTH-1:0]   B_reg_o,
  output logic [N*S*WORD_WIDTH-1:0]   M_reg_o,
  output logic [N*WORD_WIDTH-1:0]     M_prime_0_reg_o,
  output logic                        busy_o,
  output logic                        load_done_o,
  output logic                        store_done_o
);

  localparam int NS       = N*S;
  localparam int POLY_W   = NS*WORD_WIDTH;
  localparam int MP_W     = N*WORD_WIDTH;
  localparam int FULL_LEN = 3*NS+N;
  localparam int RES_OFF  = 3*NS+N;
  localparam int CNT_W    = $clog2(FULL_LEN+1);

  typedef enum logic [2:0] {IDLE, LOAD, LOAD_DRAIN, STORE, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_LEN-1:0]   base_q, base_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      iss_q, iss_d;
  logic [CNT_W-1:0]      cap_q, cap_d;
  logic [RD_LAT-1:0]     vld_q, vld_d;
  logic                  we_q, we_d;
  logic [ADDR_LEN-1:0]   addr_q, addr_d;
  logic [BRAM_WIDTH-1:0] din_q, din_d;
  logic [POLY_W-1:0]     a_q, a_d, b_q, b_d, m_q, m_d, res_q, res_d;
  logic [MP_W-1:0]       mp_q, mp_d;
  logic                  busy_q, busy_d;
  logic                  ld_done_q, ld_done_d;
  logic                  st_done_q, st_done_d;
  logic                  cap_fire_s;
  logic [WORD_WIDTH-1:0] word_s;
  logic [CNT_W-1:0]      off_s;
  logic                  dout_unused_s;

  // Only the low WORD_WIDTH bits of the BRAM read port carry operand data.
  assign dout_unused_s = ^bram_dout_i;
  assign cap_fire_s    = vld_q[RD_LAT-1];
  assign word_s        = bram_dout_i[WORD_WIDTH-1:0];

  // Next-state logic: sequencing, BRAM address/data, operand steering, RES capture.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    iss_d     = iss_q;
    cap_d     = cap_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    a_d       = a_q;
    b_d       = b_q;
    m_d       = m_q;
    mp_d      = mp_q;
    ld_done_d = 1'b0;
    st_done_d = 1'b0;
    off_s     = '0;
    vld_d     = '0;

    // An address is in flight for every LOAD cycle; it returns RD_LAT cycles later.
    vld_d[0] = (state_q == LOAD);
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    // RES is frozen while a store is streaming it out.
    if (res_we_i && (state_q != STORE)) begin
      res_d = res_din_i;
    end else begin
      res_d = res_q;
    end

    // The capture counter steers each returning word into its region.
    if (cap_fire_s) begin
      cap_d = cap_q + CNT_W'(1);
      if (cap_q < CNT_W'(NS)) begin
        off_s = cap_q;
        a_d[off_s*WORD_WIDTH +: WORD_WIDTH] = word_s;
      end else if (cap_q < CNT_W'(2*NS)) begin
        off_s = cap_q - CNT_W'(NS);
        b_d[off_s*WORD_WIDTH +: WORD_WIDTH] = word_s;
      end else if (cap_q < CNT_W'(3*NS)) begin
        off_s = cap_q - CNT_W'(2*NS);
        m_d[off_s*WORD_WIDTH +: WORD_WIDTH] = word_s;
      end else begin
        off_s = cap_q - CNT_W'(3*NS);
        mp_d[off_s*WORD_WIDTH +: WORD_WIDTH] = word_s;
      end
    end else begin
      cap_d = cap_q;
    end

    case (state_q)
      IDLE: begin
        if (load_start_i) begin
          state_d = LOAD;
          base_d  = base_addr_i;
          len_d   = load_mode_i ? CNT_W'(NS) : CNT_W'(FULL_LEN);
          addr_d  = base_addr_i;
          iss_d   = CNT_W'(1);
          cap_d   = '0;
        end else if (store_start_i) begin
          // First word comes from res_d so a same-cycle capture is what gets stored.
          state_d = STORE;
          base_d  = base_addr_i;
          we_d    = 1'b1;
          addr_d  = base_addr_i + ADDR_LEN'(RES_OFF);
          din_d   = BRAM_WIDTH'(res_d[WORD_WIDTH-1:0]);
          iss_d   = CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (iss_q == len_q) begin
          state_d = LOAD_DRAIN;
        end else begin
          addr_d = base_q + ADDR_LEN'(iss_q);
          iss_d  = iss_q + CNT_W'(1);
        end
      end
      LOAD_DRAIN: begin
        if (cap_fire_s && (cap_q == len_q - CNT_W'(1))) begin
          state_d   = DONE;
          ld_done_d = 1'b1;
        end else begin
          state_d = LOAD_DRAIN;
        end
      end
      STORE: begin
        if (iss_q == CNT_W'(NS)) begin
          state_d   = DONE;
          st_done_d = 1'b1;
        end else begin
          we_d   = 1'b1;
          addr_d = base_q + ADDR_LEN'(RES_OFF) + ADDR_LEN'(iss_q);
          din_d  = BRAM_WIDTH'(res_q[iss_q*WORD_WIDTH +: WORD_WIDTH]);
          iss_d  = iss_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any operation and clears every register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      iss_q     <= '0;
      cap_q     <= '0;
      vld_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= '0;
      mp_q      <= '0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      iss_q     <= iss_d;
      cap_q     <= cap_d;
      vld_q     <= vld_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      a_q       <= a_d;
      b_q       <= b_d;
      m_q       <= m_d;
      mp_q      <= mp_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      ld_done_q <= ld_done_d;
      st_done_q <= st_done_d;
    end
  end

  assign bram_we_o       = we_q;
  assign bram_addr_o     = addr_q;
  assign bram_din_o      = din_q;
  assign A_reg_o         = a_q;
  assign B_reg_o         = b_q;
  assign M_reg_o         = m_q;
  assign M_prime_0_reg_o = mp_q;
  assign busy_o          = busy_q;
  assign load_done_o     = ld_done_q;
  assign store_done_o    = st_done_q;

endmodule

// File: tb/tb_poly_memory_ctrl.sv
// tb_poly_memory_ctrl: randomized self-checking bench. Two instances share the
// stimulus: u_dut1 (RD_LAT=1) and u_dut3 (RD_LAT=3). A shared BRAM model feeds
// each instance through its own read-latency pipeline. Expected register
// contents come straight from the memory layout.
module tb_poly_memory_ctrl;
  localparam int WW   = 17;
  localparam int N    = 5;
  localparam int S    = 4;
  localparam int NS   = N*S;
  localparam int BW   = 32;
  localparam int AL   = 8;
  localparam int PW   = NS*WW;
  localparam int MPW  = N*WW;
  localparam int FULL = 3*NS+N;
  localparam int RESO = 3*NS+N;

  logic clock = 1'b0;
  logic reset, load_start, load_mode, store_start, res_we;
  logic [AL-1:0] base_addr;
  logic [PW-1:0] res_din;
  logic [BW-1:0] dout1, dout3;
  logic d1_we, d3_we, d1_busy, d3_busy, d1_ld, d3_ld, d1_st, d3_st;
  logic [AL-1:0] d1_addr, d3_addr;
  logic [BW-1:0] d1_din, d3_din;
  logic [PW-1:0] d1_a, d1_b, d1_m, d3_a, d3_b, d3_m;
  logic [MPW-1:0] d1_mp, d3_mp;

  logic [31:0] mem [0:255];
  logic bd_we;
  logic [AL-1:0] bd_addr;
  logic [31:0] bd_data;
  logic [31:0] rd1;
  logic [2:0][31:0] rd3;

  int n_tests = 0;
  int n_fail  = 0;
  logic [PW-1:0] sv_b, sv_m;
  logic [MPW-1:0] sv_mp;
  logic [PW-1:0] last_res;

  always #5 clock = ~clock;

  poly_memory_ctrl #(.RD_LAT(1)) u_dut1 (
    .clock(clock), .reset(reset), .load_start_i(load_start), .load_mode_i(load_mode),
    .store_start_i(store_start), .base_addr_i(base_addr), .bram_dout_i(dout1),
    .res_we_i(res_we), .res_din_i(res_din), .bram_we_o(d1_we), .bram_addr_o(d1_addr),
    .bram_din_o(d1_din), .A_reg_o(d1_a), .B_reg_o(d1_b), .M_reg_o(d1_m),
    .M_prime_0_reg_o(d1_mp), .busy_o(d1_busy), .load_done_o(d1_ld), .store_done_o(d1_st));

  poly_memory_ctrl #(.RD_LAT(3)) u_dut3 (
    .clock(clock), .reset(reset), .load_start_i(load_start), .load_mode_i(load_mode),
    .store_start_i(store_start), .base_addr_i(base_addr), .bram_dout_i(dout3),
    .res_we_i(res_we), .res_din_i(res_din), .bram_we_o(d3_we), .bram_addr_o(d3_addr),
    .bram_din_o(d3_din), .A_reg_o(d3_a), .B_reg_o(d3_b), .M_reg_o(d3_m),
    .M_prime_0_reg_o(d3_mp), .busy_o(d3_busy), .load_done_o(d3_ld), .store_done_o(d3_st));

  // BRAM model: backdoor or dut1 writes, read data delayed 1 and 3 cycles.
  always @(posedge clock) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (d1_we) mem[d1_addr] <= d1_din;
    rd1 <= mem[d1_addr];
    rd3 <= {rd3[1:0], mem[d3_addr]};
  end
  assign dout1 = rd1;
  assign dout3 = rd3[2];

  // Random words into mem[first .. first+count-1]
  task automatic fill_mem(input int first, input int count);
    @(negedge clock);
    bd_we = 1'b1;
    for (int k = 0; k < count; k++) begin
      bd_addr = 8'(first + k);
      bd_data = $urandom;
      @(negedge clock);
    end
    bd_we = 1'b0;
  endtask

  // Expected operand registers from the memory layout at base b
  task automatic build_exp(input logic [AL-1:0] b, output logic [PW-1:0] ea,
                           output logic [PW-1:0] eb, output logic [PW-1:0] em,
                           output logic [MPW-1:0] emp);
    logic [31:0] w;
    for (int k = 0; k < NS; k++) begin
      w = mem[8'(b + k)];          ea[k*WW +: WW] = w[WW-1:0];
      w = mem[8'(b + NS + k)];     eb[k*WW +: WW] = w[WW-1:0];
      w = mem[8'(b + 2*NS + k)];   em[k*WW +: WW] = w[WW-1:0];
    end
    for (int k = 0; k < N; k++) begin
      w = mem[8'(b + 3*NS + k)];   emp[k*WW +: WW] = w[WW-1:0];
    end
  endtask

  task automatic rand_res(output logic [PW-1:0] r);
    for (int k = 0; k < NS; k++) r[k*WW +: WW] = WW'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (!d1_busy && !d3_busy) break;
    end
    @(negedge clock);
  endtask

  // Starts a load; returns cycles from accept edge to load_done (-1 on timeout),
  // dut1 writes seen, and busy seen at cycle 5.
  task automatic run_load(input bit mode, input logic [AL-1:0] b, input bit use3,
                          input bit with_store, input int store_at,
                          output int lat, output int wr, output bit busy5);
    @(negedge clock);
    load_start = 1'b1; load_mode = mode; base_addr = b; store_start = with_store;
    lat = -1; wr = 0; busy5 = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clock);
      load_start = 1'b0;
      store_start = (i == store_at);
      if (d1_we === 1'b1) wr++;
      if (i == 5) busy5 = d1_busy;
      if ((use3 ? d3_ld : d1_ld) === 1'b1) begin lat = i; break; end
    end
    store_start = 1'b0;
  endtask

  // Starts a store; optionally pulses res_we with other data mid-store.
  task automatic run_store(input logic [AL-1:0] b, input bit rw, input logic [PW-1:0] rd,
                           input bit noise, output int nwr, output int bad_addr,
                           output bit done_next);
    @(negedge clock);
    store_start = 1'b1; base_addr = b; res_we = rw; res_din = rd;
    nwr = 0; bad_addr = 0; done_next = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      store_start = 1'b0;
      if (d1_we === 1'b1) begin
        if (d1_addr !== 8'(b + RESO + nwr)) bad_addr++;
        nwr++;
      end else if (nwr > 0) begin
        done_next = (d1_st === 1'b1);
        break;
      end
      res_we  = noise && (nwr >= 3) && (nwr < 8);
      res_din = ~rd;
    end
    res_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    n_tests++; if ({d1_we, d1_busy, d1_ld, d1_st} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000", {d1_we, d1_busy, d1_ld, d1_st}); end
    n_tests++; if (d1_addr !== 8'd0 || d1_din !== 32'd0) begin n_fail++;
      $display("FAIL reset_bus: got addr %h din %h expected 0 0", d1_addr, d1_din); end
    n_tests++; if ((d1_a | d1_b | d1_m) !== {PW{1'b0}} || d1_mp !== {MPW{1'b0}}) begin n_fail++;
      $display("FAIL reset_regs: got nonzero operand registers expected 0"); end
  endtask

  task automatic test_full_load();
    logic [PW-1:0] ea, eb, em; logic [MPW-1:0] emp; int lat, wr; bit b5;
    fill_mem(0, 256);
    build_exp(8'd0, ea, eb, em, emp);
    run_load(1'b0, 8'd0, 1'b0, 1'b0, -1, lat, wr, b5);
    n_tests++; if (lat !== FULL + 2) begin n_fail++;
      $display("FAIL full_latency: got %0d expected %0d", lat, FULL + 2); end
    n_tests++; if (b5 !== 1'b1) begin n_fail++;
      $display("FAIL full_busy: got %b expected 1", b5); end
    n_tests++; if (d1_a !== ea) begin n_fail++; $display("FAIL full_A: got %h expected %h", d1_a, ea); end
    n_tests++; if (d1_b !== eb) begin n_fail++; $display("FAIL full_B: got %h expected %h", d1_b, eb); end
    n_tests++; if (d1_m !== em) begin n_fail++; $display("FAIL full_M: got %h expected %h", d1_m, em); end
    n_tests++; if (d1_mp !== emp) begin n_fail++; $display("FAIL full_Mp0: got %h expected %h", d1_mp, emp); end
    sv_b = eb; sv_m = em; sv_mp = emp;
  endtask

  task automatic test_a_reload();
    logic [PW-1:0] ea, eb, em; logic [MPW-1:0] emp; int lat, wr; bit b5;
    wait_idle();
    fill_mem(0, NS);
    build_exp(8'd0, ea, eb, em, emp);
    run_load(1'b1, 8'd0, 1'b0, 1'b0, -1, lat, wr, b5);
    n_tests++; if (lat !== NS + 2) begin n_fail++;
      $display("FAIL aonly_latency: got %0d expected %0d", lat, NS + 2); end
    n_tests++; if (d1_a !== ea) begin n_fail++; $display("FAIL aonly_A: got %h expected %h", d1_a, ea); end
    n_tests++; if (d1_b !== sv_b || d1_m !== sv_m || d1_mp !== sv_mp) begin n_fail++;
      $display("FAIL aonly_hold: got B %h expected %h", d1_b, sv_b); end
  endtask

  task automatic test_store_offset();
    logic [PW-1:0] r; int nwr, bad, badw; bit dn;
    wait_idle();
    rand_res(r);
    run_store(8'd100, 1'b1, r, 1'b0, nwr, bad, dn);
    n_tests++; if (nwr !== NS) begin n_fail++; $display("FAIL store_count: got %0d expected %0d", nwr, NS); end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL store_addr: got %0d bad expected 0", bad); end
    n_tests++; if (dn !== 1'b1) begin n_fail++; $display("FAIL store_done: got %b expected 1", dn); end
    @(negedge clock);
    badw = 0;
    for (int k = 0; k < NS; k++) if (mem[8'(165 + k)] !== {15'd0, r[k*WW +: WW]}) badw++;
    n_tests++; if (badw !== 0) begin n_fail++; $display("FAIL store_data: got %0d bad words expected 0", badw); end
    last_res = r;
  endtask

  task automatic test_arbitration();
    logic [PW-1:0] ea, eb, em, r1; logic [MPW-1:0] emp; int lat, wr, nwr, bad, badw; bit b5, dn;
    wait_idle();
    build_exp(8'd30, ea, eb, em, emp);
    run_load(1'b0, 8'd30, 1'b0, 1'b1, 10, lat, wr, b5);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (d1_we === 1'b1) wr++;
    end
    n_tests++; if (lat !== FULL + 2) begin n_fail++;
      $display("FAIL arb_latency: got %0d expected %0d", lat, FULL + 2); end
    n_tests++; if (wr !== 0) begin n_fail++; $display("FAIL arb_writes: got %0d expected 0", wr); end
    n_tests++; if (d1_a !== ea || d1_mp !== emp) begin n_fail++;
      $display("FAIL arb_regs: got A %h expected %h", d1_a, ea); end
    rand_res(r1);
    @(negedge clock); res_we = 1'b1; res_din = r1;
    @(negedge clock); res_we = 1'b0;
    run_store(8'd50, 1'b0, r1, 1'b1, nwr, bad, dn);
    @(negedge clock);
    badw = 0;
    for (int k = 0; k < NS; k++) if (mem[8'(50 + RESO + k)] !== {15'd0, r1[k*WW +: WW]}) badw++;
    n_tests++; if (badw !== 0 || nwr !== NS) begin n_fail++;
      $display("FAIL arb_res_freeze: got %0d bad words, %0d writes expected 0, %0d", badw, nwr, NS); end
  endtask

  task automatic test_wrap();
    logic [PW-1:0] ea, eb, em; logic [MPW-1:0] emp; int lat, wr; bit b5;
    wait_idle();
    build_exp(8'd246, ea, eb, em, emp);
    run_load(1'b0, 8'd246, 1'b1, 1'b0, -1, lat, wr, b5);
    n_tests++; if (lat !== FULL + 4) begin n_fail++;
      $display("FAIL wrap_latency: got %0d expected %0d", lat, FULL + 4); end
    n_tests++; if (d3_a !== ea || d3_b !== eb) begin n_fail++;
      $display("FAIL wrap_AB: got A %h expected %h", d3_a, ea); end
    n_tests++; if (d3_m !== em || d3_mp !== emp) begin n_fail++;
      $display("FAIL wrap_MMp: got M %h expected %h", d3_m, em); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] snap [0:11];
    logic [PW-1:0] ea, eb, em; logic [MPW-1:0] emp;
    int lat, wr, nwr, bad, badw; bit hit, b5, dn;
    wait_idle();
    for (int j = 0; j < 12; j++) snap[j] = mem[8'(20 + RESO + 8 + j)];
    @(negedge clock); store_start = 1'b1; base_addr = 8'd20;
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock); store_start = 1'b0;
      if (d1_we === 1'b1 && d1_addr === 8'(20 + RESO + 7)) begin hit = 1'b1; break; end
    end
    n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rst_reach_word7: got %b expected 1", hit); end
    reset = 1'b1;
    @(negedge clock);
    n_tests++; if ({d1_we, d1_busy} !== 2'b00) begin n_fail++;
      $display("FAIL rst_mid_ctrl: got %b expected 00", {d1_we, d1_busy}); end
    n_tests++; if ((d1_a | d1_b | d1_m) !== {PW{1'b0}} || d1_mp !== {MPW{1'b0}}) begin n_fail++;
      $display("FAIL rst_mid_regs: got nonzero registers expected 0"); end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    badw = 0;
    for (int j = 0; j < 12; j++) if (mem[8'(20 + RESO + 8 + j)] !== snap[j]) badw++;
    n_tests++; if (badw !== 0) begin n_fail++; $display("FAIL rst_no_writes: got %0d changed expected 0", badw); end
    run_store(8'd120, 1'b0, {PW{1'b0}}, 1'b0, nwr, bad, dn);
    @(negedge clock);
    badw = 0;
    for (int k = 0; k < NS; k++) if (mem[8'(120 + RESO + k)] !== 32'd0) badw++;
    n_tests++; if (badw !== 0 || nwr !== NS) begin n_fail++;
      $display("FAIL rst_res_cleared: got %0d nonzero, %0d writes expected 0, %0d", badw, nwr, NS); end
    wait_idle();
    build_exp(8'd0, ea, eb, em, emp);
    run_load(1'b0, 8'd0, 1'b0, 1'b0, -1, lat, wr, b5);
    n_tests++; if (lat !== FULL + 2 || d1_a !== ea || d1_m !== em) begin n_fail++;
      $display("FAIL rst_reload: got latency %0d expected %0d (or regs differ)", lat, FULL + 2); end
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; load_mode = 1'b0; store_start = 1'b0;
    res_we = 1'b0; res_din = '0; base_addr = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    last_res = '0;
    test_reset();
    test_full_load();
    test_a_reload();
    test_store_offset();
    test_arbitration();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
